// File: rtl/fb_loader.sv
// Frame-buffer loader: takes RGB332 pixels from a valid/ready stream and writes one
// frame of IMG_W*IMG_H pixels into a frame-buffer write port, counting completed frames.
module fb_loader #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 15
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [7:0]        dinb,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              err_sof
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam bit SINGLE = (NPIX == 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cntNext;
  logic [ADDR_W-1:0] w_wrAddr;
  logic              w_wrEn;
  logic              w_sofErr;
  logic              w_accept;
  logic              r_web;
  logic [ADDR_W-1:0] r_addrb;
  logic [7:0]        r_dinb;
  logic [7:0]        r_frameCnt;
  logic              r_errSof;

  // A one-pixel frame is already complete when the sof beat is written, so LOAD
  // must not accept another beat in that case.
  assign in_ready = (r_state != DONE) && !(SINGLE && (r_state == LOAD));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_wrEn      = 1'b0;
    w_wrAddr    = r_cnt;
    w_sofErr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && in_sof) begin
          w_wrEn      = 1'b1;
          w_wrAddr    = '0;
          w_cntNext   = SINGLE ? '0 : ADDR_W'(1);
          w_stateNext = LOAD;
        end
      end
      LOAD: begin
        if (SINGLE) begin
          w_stateNext = DONE;
        end else if (w_accept) begin
          w_wrEn = 1'b1;
          if (in_sof) begin
            w_wrAddr  = '0;
            w_cntNext = ADDR_W'(1);
            w_sofErr  = 1'b1;
          end else if (r_cnt == LAST_ADDR) begin
            w_cntNext   = '0;
            w_stateNext = DONE;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Write port is registered; address and data only move when a write happens.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_web   <= 1'b0;
      r_addrb <= '0;
      r_dinb  <= '0;
    end else begin
      r_web <= w_wrEn;
      if (w_wrEn) begin
        r_addrb <= w_wrAddr;
        r_dinb  <= in_data;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
      r_errSof   <= 1'b0;
    end else begin
      if (r_state == DONE) begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
      if (w_sofErr) begin
        r_errSof <= 1'b1;
      end
    end
  end

  assign web        = r_web;
  assign addrb      = r_addrb;
  assign dinb       = r_dinb;
  assign busy       = (r_state == LOAD);
  assign frame_done = (r_state == DONE);
  assign frame_cnt  = r_frameCnt;
  assign err_sof    = r_errSof;

endmodule

// File: tb/tb_fb_loader.sv
// Self-checking bench for fb_loader on a small 16x8 image, compared cycle by cycle
// against a frame/pixel-index reference model.
module tb_fb_loader;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 7;
  localparam int N  = W * H;

  logic          ck;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          web;
  logic [AW-1:0] addrb;
  logic [7:0]    dinb;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          err_sof;

  fb_loader #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .ck(ck), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .web(web), .addrb(addrb), .dinb(dinb), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_sof(err_sof)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int checks;
  int errors;
  int donePulses;
  bit mInFrame;
  bit mDone;
  bit mErr;
  int mPix;
  int mFrames;
  logic [AW-1:0] lastAddr;
  logic [7:0]    lastData;
  bit lastAccepted;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mInFrame = 0; mDone = 0; mErr = 0; mPix = 0; mFrames = 0;
    lastAddr = '0; lastData = '0;
  endtask

  // One clock cycle: drive a beat, predict its effect, then check every output after the edge.
  task automatic applyStimulus(input bit v, input bit sof, input logic [7:0] d);
    bit prevDone, expWe, doneNext, accept;
    in_valid = v; in_sof = sof; in_data = d;
    #1;
    checkOutput("in_ready", in_ready, !mDone);
    accept = v && !mDone;
    lastAccepted = accept;
    prevDone = mDone;
    expWe = 0;
    doneNext = 0;
    if (accept && (mInFrame || sof)) begin
      expWe = 1;
      if (sof) begin
        if (mInFrame) mErr = 1;
        lastAddr = '0;
        mPix = 1;
        mInFrame = 1;
      end else begin
        lastAddr = AW'(mPix);
        mPix++;
      end
      lastData = d;
      if (mPix == N) begin
        mPix = 0;
        mInFrame = 0;
        doneNext = 1;
      end
    end
    mDone = doneNext;
    if (prevDone) mFrames = (mFrames + 1) % 256;
    @(posedge ck);
    #1;
    checkOutput("web", web, expWe);
    checkOutput("addrb", addrb, lastAddr);
    checkOutput("dinb", dinb, lastData);
    checkOutput("frame_done", frame_done, mDone);
    checkOutput("busy", busy, mInFrame);
    checkOutput("frame_cnt", frame_cnt, mFrames[7:0]);
    checkOutput("err_sof", err_sof, mErr);
    if (frame_done === 1'b1) donePulses++;
  endtask

  // Asynchronous reset pulse asserted mid-cycle; outputs must clear before any edge.
  task automatic doReset();
    in_valid = 0; in_sof = 0;
    #3 rst_n = 0;
    #1;
    checkOutput("rst_web", web, 0);
    checkOutput("rst_addrb", addrb, 0);
    checkOutput("rst_dinb", dinb, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_err_sof", err_sof, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    modelReset();
    @(posedge ck);
    #3 rst_n = 1;
  endtask

  task automatic sendBeat(input bit sof, input logic [7:0] d, input bit gaps);
    int tries;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 0; g++) applyStimulus(0, 0, 8'($urandom));
    end
    tries = 0;
    do begin
      applyStimulus(1, sof, d);
      tries++;
    end while (!lastAccepted && tries < 4);
    if (!lastAccepted) begin
      errors++;
      $display("[TB] FAIL beat_bound observed=not_accepted expected=accepted");
    end
  endtask

  task automatic sendFrame(input bit gaps, input bit randData);
    for (int i = 0; i < N; i++) sendBeat(i == 0, randData ? 8'($urandom) : 8'(i), gaps);
  endtask

  initial begin
    checks = 0; errors = 0; donePulses = 0;
    rst_n = 1; in_valid = 0; in_sof = 0; in_data = '0;
    lastAccepted = 0;
    modelReset();
    doReset();

    // Beats without sof while idle are dropped.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'hAA);

    // Back-to-back frame with data = address.
    sendFrame(0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00);
    checkOutput("frames_after_first", frame_cnt, 1);

    // Random valid gaps with random data.
    sendFrame(1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00);
    checkOutput("frames_after_gaps", frame_cnt, 2);

    // Restart by sof at pixel 50.
    for (int i = 0; i < 50; i++) sendBeat(i == 0, 8'($urandom), 0);
    sendFrame(0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00);
    checkOutput("err_sof_after_restart", err_sof, 1);
    checkOutput("frames_after_restart", frame_cnt, 3);

    // Reset in the middle of a frame.
    for (int i = 0; i < 60; i++) sendBeat(i == 0, 8'($urandom), 0);
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 8'h00);
    checkOutput("frames_after_reset", frame_cnt, 0);
    checkOutput("err_sof_after_reset", err_sof, 0);

    // 256 consecutive frames wrap the frame counter.
    donePulses = 0;
    for (int f = 0; f < 256; f++) sendFrame(0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00);
    checkOutput("done_pulses_256", donePulses, 256);
    checkOutput("frame_cnt_wrap", frame_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_loader.md
FB_LOADER -- requirements
Module: fb_loader

Interface
REQ-001 Parameter IMG_W, default 128, pixels per image line.
REQ-002 Parameter IMG_H, default 128, lines per image.
REQ-003 Parameter ADDR_W, default 15, frame-buffer address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-004 ck  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  8  incoming pixel, RGB332 (bits 7:5 red, 4:2 green, 1:0 blue).
REQ-007 in_valid  input  1  in_data and in_sof valid this cycle.
REQ-008 in_sof  input  1  beat is the first pixel of a frame (address 0).
REQ-009 in_ready  output  1  loader accepts a beat this cycle; a beat transfers when in_valid and in_ready are both 1.
REQ-010 web  output  1  frame-buffer write-port write enable.
REQ-011 addrb  output  ADDR_W  frame-buffer write address.
REQ-012 dinb  output  8  frame-buffer write data.
REQ-013 busy  output  1  high while in state LOAD.
REQ-014 frame_done  output  1  one-cycle pulse on completion of a full frame.
REQ-015 frame_cnt  output  8  count of completed frames.
REQ-016 err_sof  output  1  sticky flag: a frame was restarted by in_sof before completion.

Function
REQ-017 States: IDLE, LOAD, DONE; encoding free.
REQ-018 in_ready SHALL be 1 in IDLE and LOAD, 0 in DONE.
REQ-019 IDLE: accepted beat with in_sof=1 -> write pixel at address 0, pixel counter := 1, go to LOAD.
REQ-020 IDLE: accepted beat with in_sof=0 -> discarded, no write, stay IDLE.
REQ-021 LOAD: accepted beat with in_sof=0 -> write at address = pixel counter, counter increments by 1.
REQ-022 LOAD: accepted beat with in_sof=1 -> write at address 0, counter := 1, err_sof := 1, stay LOAD.
REQ-023 Write latency: web, addrb, dinb registered; web=1 exactly in the cycle after each written beat, never otherwise.
REQ-024 addrb and dinb SHALL hold their last value when web=0.
REQ-025 Accepting the beat at address IMG_W*IMG_H-1 in LOAD -> go to DONE next cycle; counter wraps to 0.
REQ-026 DONE lasts exactly one cycle: frame_done=1, frame_cnt increments (mod 256, 255 -> 0), then IDLE.
REQ-027 frame_done SHALL coincide with web=1 for the final pixel write.
REQ-028 in_valid=0 cycles in LOAD stall the counter; no timeout.
REQ-029 Beats offered while in DONE are not accepted (in_ready=0); the source must hold them.
REQ-030 With IMG_W=IMG_H=1 a single sof beat SHALL go IDLE -> LOAD -> DONE and produce one write.
REQ-031 Pixel counter width ADDR_W; addresses SHALL never reach or exceed IMG_W*IMG_H.

Reset
REQ-032 On rst_n=0, immediately and without clock: state IDLE, counter 0, web 0, addrb 0, dinb 0, busy 0, frame_done 0, frame_cnt 0, err_sof 0; in_ready follows state (1).
REQ-033 Reset mid-frame SHALL abandon the partial frame without any further write; frame_cnt is not incremented.
REQ-034 err_sof is cleared only by reset.

Verification
REQ-035 Reset, then 16384 back-to-back beats (first in_sof=1, data = addr[7:0]) -> 16384 writes, addrb 0..16383 in order, one frame_done with final write, frame_cnt=1, in_ready=0 one cycle.
REQ-036 Beats with in_sof=0 after reset (data 0xAA x5), then sof frame -> no writes for the 0xAA beats; first write addrb=0.
REQ-037 Random in_valid gaps (50 %) over one frame -> identical write sequence to REQ-035, no duplicate or skipped address.
REQ-038 in_sof=1 at pixel 1000 of a frame -> next write addrb=0, err_sof=1, frame completes 16384 beats later, frame_cnt=1.
REQ-039 rst_n low at pixel 500 for 1 cycle mid-clock -> all outputs at reset values asynchronously, no write after, frame_cnt=0.
REQ-040 256 consecutive frames -> frame_cnt wraps to 0, 256 frame_done pulses.
